// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding a single UART transmitter.
// Ports:
//   clk, rst_n (sync, active-low)
//   req0_valid/req0_data/req0_ready : requester 0 handshake
//   req1_valid/req1_data/req1_ready : requester 1 handshake
//   tx_data, tx_start, tx_done      : transmitter interface
//   busy, grant_id, timeout_err     : status
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int IFG_CYCLES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] G_LAST =
        (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    // With no inter-frame gap the frame end goes straight back to IDLE
    localparam state_t S_AFTER = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t          r_state;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            r_timeout_err;
    logic            r_grant_id;
    logic            r_last_grant;
    logic [TW-1:0]   r_tcnt;
    logic [7:0]      r_gcnt;

    logic            w_idle;
    logic            w_win0;
    logic            w_win1;

    // Requester 1 wins when alone, or on a tie when 0 was served last
    assign w_win1 = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_win0 = req0_valid & ~w_win1;

    // Readies are gated by rst_n so they stay low while reset is held
    assign w_idle     = rst_n & (r_state == S_IDLE);
    assign req0_ready = w_idle & w_win0;
    assign req1_ready = w_idle & w_win1;

    assign busy        = rst_n & (r_state != S_IDLE);
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tx_data     <= 8'h00;
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_grant_id    <= 1'b0;
            r_last_grant  <= 1'b1;
            r_tcnt        <= '0;
            r_gcnt        <= 8'd0;
        end else begin
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0_ready | req1_ready) begin
                        r_tx_data    <= req1_ready ? req1_data : req0_data;
                        r_grant_id   <= req1_ready;
                        r_last_grant <= req1_ready;
                        r_tx_start   <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // tx_done takes priority over a coincident timeout
                    if (tx_done) begin
                        r_gcnt  <= 8'd0;
                        r_state <= S_AFTER;
                    end else if (r_tcnt == T_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_gcnt        <= 8'd0;
                        r_state       <= S_AFTER;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_GAP: begin
                    if (r_gcnt == G_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Directed scenarios followed by randomized frames against a frame-level model.
module tb_uart_tx_arbiter;

    localparam int TO  = 400;
    localparam int IFG = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       busy;
    logic       grant_id;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    bit m_last;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .IFG_CYCLES    (IFG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One arbitration attempt from IDLE, followed through WAIT and GAP.
    // dly: WAIT cycle index in which tx_done pulses (if use_done).
    task automatic frame(input bit v0, input bit v1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input bit keep, input bit use_done,
                         input int dly, input bit stray);
        int         w;
        logic [7:0] b;
        bit         to_exp;
        req0_valid = v0;
        req1_valid = v1;
        req0_data  = d0;
        req1_data  = d1;
        #1;
        if (!v0 && !v1) begin
            chk("noreq_rdy", {req0_ready, req1_ready}, 0);
            step;
            chk("noreq_busy", busy, 0);
            return;
        end
        w = (v0 && v1) ? int'(!m_last) : (v1 ? 1 : 0);
        b = (w == 1) ? d1 : d0;
        chk("rdy0", req0_ready, (w == 0));
        chk("rdy1", req1_ready, (w == 1));
        chk("busy_idle", busy, 0);
        step;
        m_last = (w == 1);
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        #1;
        chk("start", tx_start, 1);
        chk("txdata", tx_data, b);
        chk("gid", grant_id, w);
        chk("busy_start", busy, 1);
        chk("rdy_start", {req0_ready, req1_ready}, 0);
        step;
        for (int k = 0; k < TO; k++) begin
            bit fire;
            fire = use_done && (k == dly);
            chk("wait", {tx_start, timeout_err, busy,
                         req0_ready, req1_ready}, 5'b00100);
            tx_done = fire;
            step;
            tx_done = 1'b0;
            if (fire) break;
        end
        to_exp = !(use_done && dly <= TO - 1);
        chk("terr", timeout_err, to_exp);
        for (int g = 0; g < IFG; g++) begin
            if (g > 0) chk("terr_once", timeout_err, 0);
            chk("gap", {busy, req0_ready, req1_ready, tx_start}, 4'b1000);
            chk("gap_data", tx_data, b);
            tx_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            step;
            tx_done = 1'b0;
        end
        chk("busy_end", busy, 0);
        chk("terr_end", timeout_err, 0);
        chk("data_hold", tx_data, b);
        chk("gid_hold", grant_id, w);
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        tx_done    = 1'b0;
        #1;
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        chk("rst_busy", busy, 0);
        step;
        chk("rst_vals", {tx_data, tx_start, timeout_err, grant_id, busy},
            12'h000);
        chk("rst_rdy2", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        m_last     = 1'b1;
        step;

        // Single request
        frame(1, 0, 8'hA5, 8'h00, 0, 1, 20, 0);

        // Tie sequence with valids held
        for (int i = 0; i < 4; i++)
            frame(1, 1, 8'h11, 8'h22, 1, 1, 3 + i, 0);

        // Long frame, ready must stay low through the gap
        frame(1, 1, 8'h5A, 8'hC3, 1, 1, 319, 0);

        // Timeout
        frame(0, 1, 8'h00, 8'h3C, 0, 0, 0, 1);

        // tx_done coincides with last WAIT count
        frame(1, 0, 8'h77, 8'h00, 0, 1, TO - 1, 0);

        // Reset in the middle of WAIT
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'hE1;
        req1_data  = 8'hE2;
        step;
        m_last = !m_last;
        step;
        step;
        step;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", {req0_ready, req1_ready}, 0);
        chk("mid_rst_busy", busy, 0);
        step;
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        m_last     = 1'b1;
        #1;
        chk("mid_rst_vals",
            {tx_data, tx_start, timeout_err, grant_id, busy}, 12'h000);
        tx_done = 1'b1;
        step;
        tx_done = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_terr", timeout_err, 0);
        frame(1, 1, 8'h90, 8'h91, 0, 1, 5, 0);

        // Randomized frames
        for (int i = 0; i < 30; i++) begin
            bit v0, v1, kp, ud, st;
            int dl;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            kp = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            ud = ($urandom_range(0, 7) != 0);
            dl = $urandom_range(0, 40);
            if ($urandom_range(0, 9) == 0) dl = TO - 1 - $urandom_range(0, 1);
            frame(v0, v1, 8'($urandom), 8'($urandom), kp, ud, dl, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1023: the maximum number of WAIT cycles before a frame is abandoned; legal range 2..65535.
REQ-002 The block SHALL have parameter IFG_CYCLES, default 2: the number of idle-gap cycles after each frame; legal range 0..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req0_valid, input, 1 bit: requester 0 has a byte to send.
REQ-006 The block SHALL have port req0_data, input, 8 bits: requester 0 byte.
REQ-007 The block SHALL have port req0_ready, output, 1 bit: requester 0 byte is accepted this cycle.
REQ-008 The block SHALL have port req1_valid, input, 1 bit: requester 1 has a byte to send.
REQ-009 The block SHALL have port req1_data, input, 8 bits: requester 1 byte.
REQ-010 The block SHALL have port req1_ready, output, 1 bit: requester 1 byte is accepted this cycle.
REQ-011 The block SHALL have port tx_data, output, 8 bits: byte presented to the transmitter's data_in.
REQ-012 The block SHALL have port tx_start, output, 1 bit: single-cycle start pulse to the transmitter.
REQ-013 The block SHALL have port tx_done, input, 1 bit: single-cycle frame-complete pulse from the transmitter.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port grant_id, output, 1 bit: the requester that owns the current or most recent frame.
REQ-016 The block SHALL have port timeout_err, output, 1 bit: single-cycle pulse when a frame is abandoned.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, START, WAIT and GAP; the state is registered.
REQ-018 In IDLE, the winner SHALL be chosen as follows: if one valid is high, that requester wins; if both are high, the requester other than last_grant wins.
REQ-019 In IDLE, reqN_ready SHALL be high combinationally for the winner only; the other ready is low; both readies are low in all other states.
REQ-020 A transfer SHALL occur when valid and ready are both high; on that edge the block latches reqN_data into tx_data, sets grant_id and last_grant to N, and moves to START.
REQ-021 In START, tx_start SHALL be high for exactly one cycle (the cycle after the transfer), followed by an unconditional move to WAIT.
REQ-022 tx_data SHALL hold stable from START until the next transfer.
REQ-023 In WAIT, the timeout counter SHALL clear on entry and increment by 1 each cycle; its width is the bit count of TIMEOUT_CYCLES and it never wraps.
REQ-024 In WAIT, tx_done = 1 SHALL move the FSM to GAP, or to IDLE if IFG_CYCLES = 0.
REQ-025 In WAIT, if the counter reaches TIMEOUT_CYCLES-1 with tx_done low, the block SHALL pulse timeout_err for one cycle on the next edge and move to GAP (or IDLE if IFG_CYCLES = 0).
REQ-026 If tx_done and the timeout condition occur in the same cycle, tx_done SHALL win and timeout_err SHALL stay low.
REQ-027 tx_done received in IDLE, START or GAP SHALL be ignored and SHALL cause no state change.
REQ-028 GAP SHALL last exactly IFG_CYCLES cycles, using its own counter cleared on entry, then move to IDLE; no requester is accepted during GAP.
REQ-029 tx_start SHALL never be asserted outside START, so the transmitter is never restarted mid-frame.
REQ-030 Minimum spacing from one transfer to the next SHALL be 3+IFG_CYCLES+(WAIT length) cycles.
REQ-031 A requester that drops valid before ready SHALL lose nothing, and arbitration SHALL re-evaluate every IDLE cycle.

Reset
REQ-032 When rst_n = 0 at a rising edge, the block SHALL take the following values regardless of state: state = IDLE, tx_data = 0x00, tx_start = 0, timeout_err = 0, grant_id = 0, last_grant = 1 (so requester 0 wins the first tie), and both counters = 0.
REQ-033 During reset, req0_ready and req1_ready SHALL be low, and busy SHALL be low.
REQ-034 Reset mid-frame SHALL abandon the frame without a timeout_err pulse; a tx_done that arrives after reset is ignored per REQ-027.

Verification
REQ-035 Single request: req0_valid = 1 with data 0xA5 in IDLE -> req0_ready high that cycle; tx_start = 1 the next cycle; tx_data = 0xA5; busy = 1; grant_id = 0.
REQ-036 Tie after reset: both valid, data0 = 0x11 and data1 = 0x22, valids held through frames -> accepted order 0x11, 0x22, 0x11, 0x22, with grant_id alternating 0, 1, 0, 1.
REQ-037 Completion and gap: tx_done pulsed 320 cycles after tx_start with IFG_CYCLES = 2 -> busy falls exactly 3 cycles after tx_done; ready is not asserted before then.
REQ-038 Timeout: TIMEOUT_CYCLES = 8, tx_done never pulsed -> timeout_err pulses once, 8 cycles after WAIT entry; the FSM returns to IDLE after the gap.
REQ-039 Simultaneous events: tx_done pulsed in the same cycle the counter equals TIMEOUT_CYCLES-1 -> timeout_err = 0 and the normal GAP is taken.
REQ-040 Reset mid-WAIT: rst_n low for 1 cycle -> next cycle all outputs are at reset values; a later stray tx_done has no effect; the next tie is granted to requester 0.
